// File: rtl/fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_pkg
//
// Shared definitions for the instruction-fetch sequencer: FSM state encoding,
// default widths, the reset fetch address and the sequential PC increment.
//
// No ports (package).
// -----------------------------------------------------------------------------
package fetch_ctrl_pkg;

    // Default widths and reset address; the top module exposes these as
    // parameters so a different configuration can override them.
    localparam int          DEF_PC_W     = 64;
    localparam int          DEF_INST_W   = 32;
    localparam logic [63:0] DEF_RESET_PC = 64'h8000_0000;

    // Sequential fetch step: fixed 4-byte instructions.
    localparam int          PC_INC       = 4;

    // Fetch sequencer states.
    //   IDLE : one cycle after reset release before the first request
    //   REQ  : request presented on the memory port
    //   WAIT : request accepted, waiting for its response
    //   HOLD : instruction held toward IF/ID until it is taken
    //   DROP : a redirected-away request is still outstanding; its response
    //          must be swallowed before a new request can go out
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_DROP = 3'd4
    } state_e;

endpackage : fetch_ctrl_pkg

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//
// Instruction-fetch sequencer in front of the IF/ID pipeline register. Owns the
// architectural fetch PC, issues one outstanding request at a time to the
// instruction memory, holds each returned instruction toward IF/ID and applies
// branch/jump redirects from EX, discarding any in-flight or held fetch.
//
// Ports:
//   clock            in   single clock, all state on posedge
//   reset            in   synchronous, active-high
//   redirect_valid   in   EX branch/jump taken this cycle
//   redirect_pc      in   redirect target (bits [1:0] forced to 0)
//   if_flush         out  combinational copy of redirect_valid (IF/ID flush)
//   imem_req_valid   out  fetch request valid (registered)
//   imem_req_addr    out  fetch address (registered)
//   imem_req_ready   in   memory accepts the request
//   imem_resp_valid  in   instruction returned (one per accepted request)
//   imem_resp_data   in   returned instruction
//   pc_valid         out  held instruction valid toward IF/ID (registered)
//   if_pc            out  PC of held instruction (registered)
//   if_instr         out  held instruction (registered)
//   if_ready         in   IF/ID accepts the held instruction
//   dbg_state        out  current FSM state, for observation only
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. imem_req_valid/imem_req_addr hold steady until accepted, except
// that a redirect may retarget an unaccepted request. pc_valid/if_pc/if_instr
// hold steady until if_ready, except that a redirect withdraws them.
// -----------------------------------------------------------------------------
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int              PC_W     = DEF_PC_W,
    parameter int              INST_W   = DEF_INST_W,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEF_RESET_PC)
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              if_flush,

    output logic              imem_req_valid,
    output logic [PC_W-1:0]   imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_resp_valid,
    input  logic [INST_W-1:0] imem_resp_data,

    output logic              pc_valid,
    output logic [PC_W-1:0]   if_pc,
    output logic [INST_W-1:0] if_instr,
    input  logic              if_ready,

    output state_e            dbg_state
);

    // -------------------------------------------------------------------------
    // State and architectural fetch PC
    // -------------------------------------------------------------------------
    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              capture;       // latch response into the IF/ID holding regs

    // Registered outputs
    logic              req_valid_q;
    logic [PC_W-1:0]   req_addr_q;
    logic              pc_valid_q;
    logic [PC_W-1:0]   if_pc_q;
    logic [INST_W-1:0] if_instr_q;

    logic [PC_W-1:0]   redirect_aligned;

    // Instructions are 4-byte aligned; the low target bits are dropped.
    assign redirect_aligned = redirect_pc & ~PC_W'(3);

    // -------------------------------------------------------------------------
    // Next-state and PC update
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        capture = 1'b0;

        unique case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                if (imem_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_resp_valid) begin
                    state_d = ST_HOLD;
                    capture = 1'b1;
                end
            end
            ST_HOLD: begin
                if (if_ready) begin
                    state_d = ST_REQ;
                    pc_d    = pc_q + PC_W'(PC_INC);   // wraps mod 2^PC_W
                end
            end
            ST_DROP: begin
                if (imem_resp_valid) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Redirect overrides everything above. Nothing fetched before the
        // redirect may reach IF/ID, so capture is always suppressed.
        if (redirect_valid) begin
            pc_d    = redirect_aligned;
            capture = 1'b0;
            unique case (state_q)
                ST_IDLE: state_d = ST_REQ;
                // An unaccepted request is simply retargeted; an accepted one
                // leaves a stale response to swallow.
                ST_REQ:  state_d = imem_req_ready  ? ST_DROP : ST_REQ;
                // If the response lands in the redirect cycle it is the stale
                // one, so nothing is left outstanding.
                ST_WAIT: state_d = imem_resp_valid ? ST_REQ  : ST_DROP;
                ST_HOLD: state_d = ST_REQ;
                // Same reasoning as WAIT: a response arriving now retires the
                // outstanding stale request, otherwise keep waiting for it.
                ST_DROP: state_d = imem_resp_valid ? ST_REQ  : ST_DROP;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // -------------------------------------------------------------------------
    // Registered outputs, derived from the next state so they line up with the
    // state register without an extra cycle of latency.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            req_valid_q <= 1'b0;
            req_addr_q  <= RESET_PC;
            pc_valid_q  <= 1'b0;
            if_pc_q     <= '0;
            if_instr_q  <= '0;
        end else begin
            req_valid_q <= (state_d == ST_REQ);
            req_addr_q  <= pc_d;
            pc_valid_q  <= (state_d == ST_HOLD);
            if (capture) begin
                if_pc_q    <= pc_q;
                if_instr_q <= imem_resp_data;
            end
        end
    end

    assign if_flush       = redirect_valid;
    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = req_addr_q;
    assign pc_valid       = pc_valid_q;
    assign if_pc          = if_pc_q;
    assign if_instr       = if_instr_q;
    assign dbg_state      = state_q;

endmodule : fetch_ctrl

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
//
// Bench for fetch_ctrl. A memory model answers accepted requests after a
// configurable delay with address-derived data; a transaction-level reference
// (fetch PC, outstanding/stale request, held instruction) predicts every cycle
// which outputs must be asserted and with which values.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    localparam int          PC_W   = 64;
    localparam int          INST_W = 32;
    localparam logic [63:0] RST_PC = 64'h8000_0000;

    // ---------------- clock / reset ----------------
    logic              clock = 1'b0;
    logic              reset = 1'b1;
    always #5 clock = ~clock;

    logic              redirect_valid = 1'b0;
    logic [PC_W-1:0]   redirect_pc    = '0;
    logic              if_flush;
    logic              imem_req_valid;
    logic [PC_W-1:0]   imem_req_addr;
    logic              imem_req_ready = 1'b0;
    logic              imem_resp_valid = 1'b0;
    logic [INST_W-1:0] imem_resp_data = '0;
    logic              pc_valid;
    logic [PC_W-1:0]   if_pc;
    logic [INST_W-1:0] if_instr;
    logic              if_ready = 1'b0;
    state_e            dbg_state;

    fetch_ctrl #(.PC_W(PC_W), .INST_W(INST_W), .RESET_PC(RST_PC)) dut (
        .clock          (clock),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_flush       (if_flush),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .pc_valid       (pc_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_ready       (if_ready),
        .dbg_state      (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;

    logic [PC_W-1:0] exp_q[$];     // accepted request addresses, in order
    int              acc_cyc_q[$]; // cycle of each acceptance
    int              cyc = 0;
    int              pv_seen = 0;  // cycles with pc_valid high

    // Reference model
    logic [PC_W-1:0] m_pc;         // next fetch address
    logic [PC_W-1:0] m_hold_pc;    // PC of instruction expected toward IF/ID
    bit              m_idle;       // first cycle after reset release
    bit              m_out;        // a request is outstanding
    bit              m_stale;      // outstanding request was redirected away
    bit              m_hold;       // an instruction is expected on pc_valid
    bit              after_rd;     // previous cycle carried a redirect

    // Memory model
    bit              mem_busy;
    int              mem_cnt;
    logic [PC_W-1:0] mem_addr;
    int              delay_cfg = 0; // <0: random 0..3 extra cycles

    function automatic logic [INST_W-1:0] mem_data(input logic [PC_W-1:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_0013;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        m_pc     = RST_PC;
        m_hold_pc = '0;
        m_idle   = 1'b1;
        m_out    = 1'b0;
        m_stale  = 1'b0;
        m_hold   = 1'b0;
        after_rd = 1'b0;
        mem_busy = 1'b0;
        mem_cnt  = 0;
    endtask

    // Assert reset for two edges, check reset values, release at a negedge.
    task automatic do_reset();
        reset           = 1'b1;
        redirect_valid  = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        if_ready        = 1'b0;
        @(negedge clock);
        @(negedge clock);
        cyc += 2;
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_req_addr",  imem_req_addr, RST_PC);
        check("rst_pc_valid",  pc_valid, 0);
        check("rst_if_pc",     if_pc, 0);
        check("rst_if_instr",  if_instr, 0);
        check("rst_state",     dbg_state, ST_IDLE);
        reset = 1'b0;
        model_clear();
    endtask

    // ---------------- driver + per-cycle monitor ----------------
    // Called at a negedge: checks current outputs against the model, drives
    // this cycle's inputs, then advances the model past the next posedge.
    task automatic step(input bit rdy, input bit ifr, input bit rd, input logic [PC_W-1:0] tgt);
        bit exp_req, rsp, acc, xfer;

        if (after_rd) check("pv_after_redirect", pc_valid, 0);
        check("pc_valid", pc_valid, m_hold);
        if (m_hold) begin
            check("if_pc", if_pc, m_hold_pc);
            check("if_instr", if_instr, mem_data(m_hold_pc));
        end
        exp_req = !m_idle && !m_out && !m_hold;
        check("req_valid", imem_req_valid, exp_req);
        if (imem_req_valid && exp_req) check("req_addr", imem_req_addr, m_pc);
        if (pc_valid) pv_seen++;

        rsp = mem_busy && (mem_cnt == 0);
        imem_req_ready  = rdy;
        if_ready        = ifr;
        redirect_valid  = rd;
        redirect_pc     = tgt;
        imem_resp_valid = rsp;
        imem_resp_data  = rsp ? mem_data(mem_addr) : $urandom;
        #1;
        check("if_flush", if_flush, rd);

        acc  = imem_req_valid && rdy;
        xfer = m_hold && ifr;

        if (rsp) begin
            m_out    = 1'b0;
            mem_busy = 1'b0;
            if (!m_stale && !rd) begin
                m_hold    = 1'b1;
                m_hold_pc = mem_addr;
            end
            m_stale = 1'b0;
        end else if (mem_busy) begin
            mem_cnt--;
        end
        if (acc) begin
            m_out    = 1'b1;
            m_stale  = rd;
            mem_busy = 1'b1;
            mem_addr = imem_req_addr;
            mem_cnt  = (delay_cfg < 0) ? $urandom_range(0, 3) : delay_cfg;
            exp_q.push_back(imem_req_addr);
            acc_cyc_q.push_back(cyc);
        end
        if (rd) begin
            if (m_out) m_stale = 1'b1;
            m_hold = 1'b0;
            m_pc   = tgt & ~64'h3;
        end else if (xfer) begin
            m_hold = 1'b0;
            m_pc   = m_hold_pc + 64'd4;
        end
        m_idle   = 1'b0;
        after_rd = rd;

        @(negedge clock);
        cyc++;
    endtask

    task automatic advance_to_hold();
        for (int i = 0; i < 20 && !m_hold; i++) step(1'b1, 1'b0, 1'b0, '0);
        check("reach_hold", pc_valid, 1);
    endtask

    task automatic run_until_acc();
        int k;
        k = exp_q.size();
        for (int i = 0; i < 20 && exp_q.size() == k; i++) step(1'b1, 1'b1, 1'b0, '0);
        check("acc_timeout", exp_q.size(), k + 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k, pv0;
        model_clear();

        // 1: zero-wait memory, if_ready=1, one instruction per 3 cycles
        do_reset();
        delay_cfg = 0;
        exp_q.delete();
        acc_cyc_q.delete();
        for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b0, '0);
        check("t1_acc_count", exp_q.size(), 3);
        if (exp_q.size() == 3) begin
            check("t1_addr0", exp_q[0], 64'h8000_0000);
            check("t1_addr1", exp_q[1], 64'h8000_0004);
            check("t1_addr2", exp_q[2], 64'h8000_0008);
            check("t1_first_cyc", acc_cyc_q[1] - acc_cyc_q[0], 3);
            check("t1_spacing", acc_cyc_q[2] - acc_cyc_q[1], 3);
        end

        // 2: IF/ID stalls 5 cycles in HOLD, then resumes at pc+4
        advance_to_hold();
        k = exp_q.size();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, '0);
        check("t2_no_req_in_stall", exp_q.size(), k);
        check("t2_hold_pc", if_pc, 64'h8000_0008);
        run_until_acc();
        check("t2_resume_addr", exp_q[$], 64'h8000_000C);

        // 3: redirect while waiting, stale response arrives later
        delay_cfg = 3;
        advance_to_hold();
        step(1'b0, 1'b1, 1'b0, '0);         // take it, go to REQ
        run_until_acc();                    // now in WAIT
        pv0 = pv_seen;
        step(1'b1, 1'b1, 1'b1, 64'h8000_0100);
        run_until_acc();
        check("t3_redirect_addr", exp_q[$], 64'h8000_0100);
        check("t3_stale_dropped", pv_seen - pv0, 0);

        // 4: redirect in HOLD with if_ready in the same cycle
        delay_cfg = 0;
        advance_to_hold();
        step(1'b1, 1'b1, 1'b1, 64'h8000_0203);
        run_until_acc();
        check("t4_redirect_addr", exp_q[$], 64'h8000_0200);

        // 5: ready low 4 cycles, redirect in the 2nd
        advance_to_hold();
        step(1'b0, 1'b1, 1'b0, '0);         // take it; REQ next
        k = exp_q.size();
        step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b1, 64'h8000_0400);
        step(1'b0, 1'b1, 1'b0, '0);
        check("t5_retarget", imem_req_addr, 64'h8000_0400);
        step(1'b0, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, '0);
        check("t5_one_accept", exp_q.size(), k + 1);
        check("t5_accept_addr", exp_q[$], 64'h8000_0400);

        // 6: reset while in DROP
        delay_cfg = 3;
        run_until_acc();
        step(1'b1, 1'b1, 1'b1, 64'h8000_0800);   // now DROP
        do_reset();
        step(1'b1, 1'b1, 1'b0, '0);             // IDLE cycle
        check("t6_req_valid", imem_req_valid, 1);
        check("t6_req_addr", imem_req_addr, RST_PC);

        // 7: random traffic
        delay_cfg = -1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 699) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                     $urandom_range(0, 9) == 0, {$urandom, $urandom});
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fetch_ctrl
